// File: rtl/button_conditioner_pkg.sv
// rtl/button_conditioner_pkg.sv - shared state encoding and channel indices for the button conditioner
package button_conditioner_pkg;

  typedef enum logic [2:0] {
    ST_RELEASED     = 3'd0,
    ST_PRESS_WAIT   = 3'd1,
    ST_PRESSED      = 3'd2,
    ST_LONG_DONE    = 3'd3,
    ST_RELEASE_WAIT = 3'd4
  } btn_state_e;

  localparam int BTN_START_STOP = 0;
  localparam int BTN_SET        = 1;
  localparam int BTN_SNOOZE     = 2;

endpackage

// File: rtl/button_conditioner_if.sv
// rtl/button_conditioner_if.sv - raw pad inputs and conditioned level/pulse outputs
interface button_conditioner_if #(
  parameter int N_BTN = 3
);

  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] press_pulse;
  logic [N_BTN-1:0] release_pulse;
  logic [N_BTN-1:0] long_pulse;

  modport master (
    output btn_raw,
    input  btn_level, press_pulse, release_pulse, long_pulse
  );

  modport slave (
    input  btn_raw,
    output btn_level, press_pulse, release_pulse, long_pulse
  );

endinterface

// File: rtl/button_conditioner_channel.sv
// rtl/button_conditioner_channel.sv - one button: 2-flop sync, debounce FSM, hold counter
module button_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 100000000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic pressed_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  logic          sync1_q, sync_q;
  btn_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic [HW-1:0] hold_q;
  logic          from_long_q;
  logic          level_q, press_q, release_q, long_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q     <= 1'b0;
      sync_q      <= 1'b0;
      state_q     <= ST_RELEASED;
      cnt_q       <= '0;
      hold_q      <= '0;
      from_long_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      sync1_q   <= pressed_i;
      sync_q    <= sync1_q;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      case (state_q)
        ST_RELEASED: begin
          if (sync_q) begin
            state_q <= ST_PRESS_WAIT;
            cnt_q   <= CW'(1);
          end
        end
        ST_PRESS_WAIT: begin
          if (!sync_q) begin
            state_q <= ST_RELEASED;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ST_PRESSED;
            cnt_q   <= '0;
            hold_q  <= '0;
            level_q <= 1'b1;
            press_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        // A release candidate takes priority over the long-press threshold
        ST_PRESSED: begin
          if (!sync_q) begin
            state_q     <= ST_RELEASE_WAIT;
            cnt_q       <= CW'(1);
            from_long_q <= 1'b0;
          end else if (hold_q == HOLD_LAST) begin
            state_q <= ST_LONG_DONE;
            long_q  <= 1'b1;
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
        ST_LONG_DONE: begin
          if (!sync_q) begin
            state_q     <= ST_RELEASE_WAIT;
            cnt_q       <= CW'(1);
            from_long_q <= 1'b1;
          end
        end
        ST_RELEASE_WAIT: begin
          if (sync_q) begin
            state_q <= from_long_q ? ST_LONG_DONE : ST_PRESSED;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= ST_RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= ST_RELEASED;
      endcase
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - N independent button channels with optional pad inversion
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 100000000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  button_conditioner_if.slave  bus
);

  logic [N_BTN-1:0] pressed_w;
  logic [N_BTN-1:0] level_w, press_w, release_w, long_w;

  assign pressed_w = (ACTIVE_LOW != 0) ? ~bus.btn_raw : bus.btn_raw;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES)
    ) u_channel (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .pressed_i (pressed_w[i]),
      .level_o   (level_w[i]),
      .press_o   (press_w[i]),
      .release_o (release_w[i]),
      .long_o    (long_w[i])
    );
  end

  assign bus.btn_level     = level_w;
  assign bus.press_pulse   = press_w;
  assign bus.release_pulse = release_w;
  assign bus.long_pulse    = long_w;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - randomized and directed bench with a run-length reference model
module tb_button_conditioner;
  import button_conditioner_pkg::*;

  localparam int DEB  = 4;
  localparam int LONG = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc_no = 0;

  button_conditioner_if #(.N_BTN(3)) bus ();

  button_conditioner #(
    .N_BTN(3), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG), .ACTIVE_LOW(1)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference: a change is accepted once DEB consecutive synchronised samples
  // disagree with the level; hold advances on every held sample that follows a held one.
  logic [2:0] exp_level, exp_press, exp_rel, exp_long;
  bit         m_s1 [3];
  bit         m_s  [3];
  bit         m_prev [3];
  bit         m_fired [3];
  int         m_run [3];
  int         m_hold [3];
  bit         smp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_level = '0; exp_press = '0; exp_rel = '0; exp_long = '0;
      for (int c = 0; c < 3; c++) begin
        m_s1[c] = 0; m_s[c] = 0; m_prev[c] = 0; m_fired[c] = 0; m_run[c] = 0; m_hold[c] = 0;
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        smp = m_s[c];
        m_s[c] = m_s1[c];
        m_s1[c] = ~bus.btn_raw[c];
        exp_press[c] = 0; exp_rel[c] = 0; exp_long[c] = 0;
        if (smp != exp_level[c]) m_run[c]++; else m_run[c] = 0;
        if (m_run[c] == DEB) begin
          m_run[c] = 0;
          exp_level[c] = ~exp_level[c];
          if (exp_level[c]) begin
            exp_press[c] = 1; m_hold[c] = 0; m_fired[c] = 0;
          end else begin
            exp_rel[c] = 1;
          end
        end else if (exp_level[c] && smp && m_prev[c] && !m_fired[c]) begin
          m_hold[c]++;
          if (m_hold[c] == LONG) begin
            exp_long[c] = 1; m_fired[c] = 1;
          end
        end
        m_prev[c] = smp;
      end
    end
  end

  int p_cnt [3], r_cnt [3], l_cnt [3];
  int p_time [3], r_time [3], l_time [3];

  function automatic logic [11:0] dut_outs();
    return {bus.btn_level, bus.press_pulse, bus.release_pulse, bus.long_pulse};
  endfunction

  function automatic logic [11:0] exp_outs();
    return {exp_level, exp_press, exp_rel, exp_long};
  endfunction

  task automatic clr();
    for (int c = 0; c < 3; c++) begin
      p_cnt[c] = 0; r_cnt[c] = 0; l_cnt[c] = 0;
      p_time[c] = -1; r_time[c] = -1; l_time[c] = -1;
    end
  endtask

  task automatic cyc(input logic [2:0] raw);
    bus.btn_raw = raw;
    @(posedge clk);
    #1;
    cyc_no++;
    for (int c = 0; c < 3; c++) begin
      if (bus.press_pulse[c])   begin p_cnt[c]++; p_time[c] = cyc_no; end
      if (bus.release_pulse[c]) begin r_cnt[c]++; r_time[c] = cyc_no; end
      if (bus.long_pulse[c])    begin l_cnt[c]++; l_time[c] = cyc_no; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.btn_raw = 3'b111;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dut_outs() !== 12'h000) begin
      failures++; $display("FAIL reset_hold got=%h exp=000", dut_outs());
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(3'b111);
      checks++;
      if (dut_outs() !== 12'h000 || dut_outs() !== exp_outs()) begin
        failures++; $display("FAIL reset_idle cyc=%0d got=%h exp=000", cyc_no, dut_outs());
      end
    end
  endtask

  task automatic test_clean_press();
    int t0;
    clr(); t0 = cyc_no;
    for (int i = 0; i < 20; i++) begin
      cyc(i < 10 ? 3'b110 : 3'b111);
      checks++;
      if (dut_outs() !== exp_outs()) begin
        failures++; $display("FAIL clean_model cyc=%0d got=%h exp=%h", cyc_no, dut_outs(), exp_outs());
      end
    end
    checks++;
    if (p_cnt[0] !== 1 || p_time[0] !== t0 + 6) begin
      failures++; $display("FAIL clean_press cnt=%0d at=%0d exp cnt=1 at=%0d", p_cnt[0], p_time[0], t0 + 6);
    end
    checks++;
    if (p_cnt[1] + p_cnt[2] + l_cnt[0] !== 0) begin
      failures++; $display("FAIL clean_other got=%0d exp=0", p_cnt[1] + p_cnt[2] + l_cnt[0]);
    end
    checks++;
    if (r_cnt[0] !== 1 || r_time[0] !== t0 + 16) begin
      failures++; $display("FAIL clean_release cnt=%0d at=%0d exp cnt=1 at=%0d", r_cnt[0], r_time[0], t0 + 16);
    end
  endtask

  task automatic test_bounce();
    bit seen;
    clr(); seen = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(i < 20 ? {1'b1, ((i / 2) % 2 == 0) ? 1'b0 : 1'b1, 1'b1} : 3'b111);
      if (bus.btn_level[1]) seen = 1;
      checks++;
      if (dut_outs() !== exp_outs()) begin
        failures++; $display("FAIL bounce_model cyc=%0d got=%h exp=%h", cyc_no, dut_outs(), exp_outs());
      end
    end
    checks++;
    if (p_cnt[1] !== 0 || seen) begin
      failures++; $display("FAIL bounce_press cnt=%0d level_seen=%0d exp 0 0", p_cnt[1], seen);
    end
  endtask

  task automatic test_long();
    int t0;
    clr(); t0 = cyc_no;
    for (int i = 0; i < 42; i++) begin
      cyc(i < 30 ? 3'b011 : 3'b111);
      checks++;
      if (dut_outs() !== exp_outs()) begin
        failures++; $display("FAIL long_model cyc=%0d got=%h exp=%h", cyc_no, dut_outs(), exp_outs());
      end
    end
    checks++;
    if (p_time[2] !== t0 + 6) begin
      failures++; $display("FAIL long_press at=%0d exp=%0d", p_time[2], t0 + 6);
    end
    checks++;
    if (l_cnt[2] !== 1 || l_time[2] !== t0 + 18) begin
      failures++; $display("FAIL long_pulse cnt=%0d at=%0d exp cnt=1 at=%0d", l_cnt[2], l_time[2], t0 + 18);
    end
    checks++;
    if (r_cnt[2] !== 1 || r_time[2] !== t0 + 36) begin
      failures++; $display("FAIL long_release cnt=%0d at=%0d exp cnt=1 at=%0d", r_cnt[2], r_time[2], t0 + 36);
    end
  endtask

  task automatic test_glitch();
    clr();
    for (int i = 0; i < 26; i++) begin
      cyc((i < 10 || (i >= 12 && i < 16)) ? 3'b110 : 3'b111);
      checks++;
      if (dut_outs() !== exp_outs()) begin
        failures++; $display("FAIL glitch_model cyc=%0d got=%h exp=%h", cyc_no, dut_outs(), exp_outs());
      end
      if (i == 15) begin
        checks++;
        if (r_cnt[0] !== 0 || bus.btn_level[0] !== 1'b1) begin
          failures++; $display("FAIL glitch_hold rel=%0d level=%0d exp 0 1", r_cnt[0], bus.btn_level[0]);
        end
      end
    end
    checks++;
    if (p_cnt[0] !== 1 || r_cnt[0] !== 1 || l_cnt[0] !== 0) begin
      failures++; $display("FAIL glitch_counts p=%0d r=%0d l=%0d exp 1 1 0", p_cnt[0], r_cnt[0], l_cnt[0]);
    end
  endtask

  task automatic test_reset_mid();
    int t1;
    clr();
    for (int i = 0; i < 8; i++) cyc(3'b101);
    checks++;
    if (bus.btn_level[1] !== 1'b1) begin
      failures++; $display("FAIL midrst_pre level=%0d exp=1", bus.btn_level[1]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (dut_outs() !== 12'h000) begin
      failures++; $display("FAIL midrst_drop got=%h exp=000", dut_outs());
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    t1 = cyc_no;
    for (int i = 0; i < 20; i++) begin
      cyc(i < 10 ? 3'b101 : 3'b111);
      checks++;
      if (dut_outs() !== exp_outs()) begin
        failures++; $display("FAIL midrst_model cyc=%0d got=%h exp=%h", cyc_no, dut_outs(), exp_outs());
      end
      if (i == 9) begin
        checks++;
        if (r_cnt[1] !== 0 || p_time[1] !== t1 + 6) begin
          failures++; $display("FAIL midrst_repress rel=%0d at=%0d exp 0 at=%0d", r_cnt[1], p_time[1], t1 + 6);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    int t0;
    clr(); t0 = cyc_no;
    for (int i = 0; i < 20; i++) cyc(i < 10 ? 3'b000 : 3'b111);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (p_cnt[c] !== 1 || p_time[c] !== t0 + 6 || r_time[c] !== t0 + 16) begin
        failures++; $display("FAIL simul_ch%0d p=%0d at=%0d rel_at=%0d exp 1 %0d %0d",
                             c, p_cnt[c], p_time[c], r_time[c], t0 + 6, t0 + 16);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] raw;
    int         left [3];
    raw = 3'b111;
    for (int c = 0; c < 3; c++) left[c] = 0;
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < 3; c++) begin
        if (left[c] == 0) begin
          raw[c] = ~raw[c];
          left[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 40) : $urandom_range(1, 7);
        end
        left[c]--;
      end
      cyc(raw);
      checks++;
      if (dut_outs() !== exp_outs()) begin
        failures++; $display("FAIL random_model cyc=%0d got=%h exp=%h", cyc_no, dut_outs(), exp_outs());
      end
    end
    for (int i = 0; i < 12; i++) cyc(3'b111);
  endtask

  initial begin
    bus.btn_raw = 3'b111;
    clr();
    test_reset();
    test_clean_press();
    test_bounce();
    test_long();
    test_glitch();
    test_reset_mid();
    test_simultaneous();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
